// File: rtl/alu.sv
// ==========================================================================
// Module   : alu
// Brief    : 64-bit ADD/SUB/AND/XOR execute-stage ALU with a registered result
//            and signed-overflow flag. Defining ALU_CC_EN adds a ZF/SF/OF
//            condition-code register.
// Revision : 1.0 - initial release
// ==========================================================================
`default_nettype none

module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  control,
    input  logic [63:0] a,
    input  logic [63:0] b,
`ifdef ALU_CC_EN
    input  logic        set_cc,
    output logic        zf,
    output logic        sf,
    output logic        of,
`endif
    output logic [63:0] result,
    output logic        overflow,
    output logic        out_valid
);

    localparam logic [1:0] c_OP_ADD = 2'd0;
    localparam logic [1:0] c_OP_SUB = 2'd1;
    localparam logic [1:0] c_OP_AND = 2'd2;
    localparam logic [1:0] c_OP_XOR = 2'd3;

    logic        w_is_sub;
    logic [63:0] w_bop;
    logic [63:0] w_sum;
    logic [63:0] w_carry;
    logic [63:0] w_result;
    logic        w_overflow;

    logic [63:0] r_result;
    logic        r_overflow;
    logic        r_out_valid;

    // SUB shares the adder: invert b and inject the +1 as the carry-in.
    assign w_is_sub   = (control == c_OP_SUB);
    assign w_bop      = w_is_sub ? ~b : b;
    assign w_carry[0] = w_is_sub;

    genvar i;
    generate
        for (i = 0; i < 64; i++) begin : g_fa
            assign w_sum[i] = a[i] ^ w_bop[i] ^ w_carry[i];
            if (i < 63) begin : g_carry
                assign w_carry[i+1] = (a[i] & w_bop[i]) | (w_carry[i] & (a[i] ^ w_bop[i]));
            end
        end
    endgenerate

    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (control)
            c_OP_ADD, c_OP_SUB: begin
                w_result   = w_sum;
                w_overflow = (a[63] == w_bop[63]) && (w_sum[63] != a[63]);
            end
            c_OP_AND: w_result = a & b;
            c_OP_XOR: w_result = a ^ b;
            default:  w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result   <= w_result;
                r_overflow <= w_overflow;
            end
        end
    end

    assign result    = r_result;
    assign overflow  = r_overflow;
    assign out_valid = r_out_valid;

`ifdef ALU_CC_EN
    logic r_zf;
    logic r_sf;
    logic r_of;

    // Flags come from the same combinational values that load result/overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (in_valid && set_cc) begin
            r_zf <= (w_result == 64'd0);
            r_sf <= w_result[63];
            r_of <= w_overflow;
        end
    end

    assign zf = r_zf;
    assign sf = r_sf;
    assign of = r_of;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// ==========================================================================
// Module   : tb_alu
// Brief    : Directed self-checking bench for alu (CC checks under ALU_CC_EN).
// Revision : 1.0 - initial release
// ==========================================================================
`default_nettype none

module tb_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  control;
    logic [63:0] a;
    logic [63:0] b;
    logic        set_cc;
    logic [63:0] result;
    logic        overflow;
    logic        out_valid;
    logic        zf;
    logic        sf;
    logic        of;

    int total;
    int bad;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .control   (control),
        .a         (a),
        .b         (b),
`ifdef ALU_CC_EN
        .set_cc    (set_cc),
        .zf        (zf),
        .sf        (sf),
        .of        (of),
`endif
        .result    (result),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

`ifndef ALU_CC_EN
    assign zf = 1'b0;
    assign sf = 1'b0;
    assign of = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one operation, let it be captured, then sample 1 time unit later.
    task automatic op(input logic [1:0] ctl, input logic [63:0] opa,
                      input logic [63:0] opb, input logic cc);
        @(negedge clk);
        in_valid = 1'b1;
        control  = ctl;
        a        = opa;
        b        = opb;
        set_cc   = cc;
        @(posedge clk);
        #1;
    endtask

    task automatic res(input string tag, input logic [63:0] r, input logic ov);
        chk({tag, "_res"}, result, r);
        chk({tag, "_ov"}, {63'd0, overflow}, {63'd0, ov});
        chk({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        control  = 2'd0;
        a        = '0;
        b        = '0;
        set_cc   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", result, 64'd0);
        chk("rst_ov", {63'd0, overflow}, 64'd0);
        chk("rst_vld", {63'd0, out_valid}, 64'd0);
`ifdef ALU_CC_EN
        chk("rst_cc", {61'd0, zf, sf, of}, 64'd4);
`endif
        @(negedge clk);
        rst = 1'b0;

        // ADD
        op(2'd0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        res("add_mix", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        res("add_m1m5", 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        op(2'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        res("add_1m5", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        op(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        res("add_ovp", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        op(2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0);
        res("add_ovn", 64'h0000_0000_0000_0001, 1'b1);

        // SUB
        op(2'd1, 64'd3, 64'd2, 1'b0);
        res("sub_3m2", 64'd1, 1'b0);
        op(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        res("sub_m1mm5", 64'd4, 1'b0);
        op(2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        res("sub_ov", 64'h8000_0000_0000_0004, 1'b1);
        op(2'd1, 64'd0, 64'h8000_0000_0000_0000, 1'b0);
        res("sub_minint", 64'h8000_0000_0000_0000, 1'b1);

        // AND / XOR
        op(2'd2, 64'd1, 64'd5, 1'b0);
        res("and_1_5", 64'd1, 1'b0);
        op(2'd3, 64'd1, 64'd5, 1'b0);
        res("xor_1_5", 64'd4, 1'b0);
        op(2'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        res("and_min", 64'h8000_0000_0000_0000, 1'b0);
        op(2'd3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        res("xor_min", 64'h7FFF_FFFF_FFFF_FFFB, 1'b0);
        op(2'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        res("and_max", 64'h7FFF_FFFF_FFFF_FFFB, 1'b0);
        op(2'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        res("xor_max", 64'h8000_0000_0000_0004, 1'b0);

        // Hold: result persists while out_valid drops
        op(2'd0, 64'd10, 64'd20, 1'b0);
        res("hold_issue", 64'd30, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        control  = 2'd3;
        a        = 64'hDEAD;
        b        = 64'hBEEF;
        @(posedge clk);
        #1;
        chk("hold1_res", result, 64'd30);
        chk("hold1_vld", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk("hold2_res", result, 64'd30);
        chk("hold2_vld", {63'd0, out_valid}, 64'd0);

        // Back-to-back
        op(2'd0, 64'd100, 64'd1, 1'b0);
        res("b2b0", 64'd101, 1'b0);
        op(2'd1, 64'd100, 64'd1, 1'b0);
        res("b2b1", 64'd99, 1'b0);
        op(2'd2, 64'hF0, 64'h3C, 1'b0);
        res("b2b2", 64'h30, 1'b0);
        op(2'd3, 64'hF0, 64'h3C, 1'b0);
        res("b2b3", 64'hCC, 1'b0);

        // Reset wins over a concurrent overflowing ADD
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        control  = 2'd0;
        a        = 64'h7FFF_FFFF_FFFF_FFFF;
        b        = 64'h7FFF_FFFF_FFFF_FFFF;
        set_cc   = 1'b1;
        @(posedge clk);
        #1;
        chk("rstop_res", result, 64'd0);
        chk("rstop_ov", {63'd0, overflow}, 64'd0);
        chk("rstop_vld", {63'd0, out_valid}, 64'd0);
`ifdef ALU_CC_EN
        chk("rstop_cc", {61'd0, zf, sf, of}, 64'd4);
`endif
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        set_cc   = 1'b0;

`ifdef ALU_CC_EN
        op(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        chk("cc_ov", {61'd0, zf, sf, of}, 64'd3);
        op(2'd1, 64'd5, 64'd5, 1'b1);
        res("cc_sub55", 64'd0, 1'b0);
        chk("cc_zero", {61'd0, zf, sf, of}, 64'd4);
        op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
        res("cc_nocc", 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        chk("cc_hold", {61'd0, zf, sf, of}, 64'd4);
`endif

        @(negedge clk);
        in_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
